// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: fills lead slots with preamble/SFD, passes data while computing CRC-32, appends FCS.
// Define GMII_TX_STATS_EN to build the frame_count/err_count statistics counters.
module gmii_tx_framer #(
    parameter int LEAD = 4
) (
    input  logic        tx_clk,
    input  logic        rst,
    input  logic        strobe_s,
    input  logic        strobe_l,
    input  logic [7:0]  mac_data,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en,
    output logic        gmii_tx_er,
    output logic        busy,
    output logic [15:0] frame_count,
    output logic [15:0] err_count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        DATA  = 3'd2,
        FCS   = 3'd3,
        ABORT = 3'd4
    } state_t;

    localparam logic [3:0]  LEAD_CNT = 4'(LEAD);
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
    localparam logic [7:0]  PRE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE = 8'hD5;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  lead_cnt;
    logic [3:0]  lead_nxt;
    logic [2:0]  trl_cnt;
    logic [2:0]  trl_nxt;
    logic [31:0] crc;
    logic [31:0] crc_nxt;
    logic [31:0] fcs_word;
    logic [7:0]  txd_nxt;
    logic        en_nxt;
    logic        er_nxt;
    logic        fault;

    // Reflected CRC-32, one byte per call, LSB first.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    assign fcs_word = crc >> {trl_cnt[1:0], 3'b000};

    always_comb begin
        state_nxt = state;
        lead_nxt  = lead_cnt;
        trl_nxt   = trl_cnt;
        crc_nxt   = crc;
        txd_nxt   = 8'h00;
        en_nxt    = 1'b0;
        er_nxt    = 1'b0;
        fault     = 1'b0;

        case (state)
            IDLE: begin
                crc_nxt  = CRC_INIT;
                lead_nxt = 4'd0;
                trl_nxt  = 3'd0;
                if (strobe_s) begin
                    state_nxt = ABORT;
                end else if (strobe_l) begin
                    state_nxt = PRE;
                    lead_nxt  = 4'd1;
                    txd_nxt   = (LEAD_CNT == 4'd1) ? SFD_BYTE : PRE_BYTE;
                    en_nxt    = 1'b1;
                end
            end

            PRE: begin
                if (!strobe_l) begin
                    fault = 1'b1;
                end else if (strobe_s) begin
                    if (lead_cnt == LEAD_CNT) begin
                        state_nxt = DATA;
                        txd_nxt   = mac_data;
                        en_nxt    = 1'b1;
                        crc_nxt   = crc_step(crc, mac_data);
                    end else begin
                        fault = 1'b1;
                    end
                end else if (lead_cnt < LEAD_CNT) begin
                    lead_nxt = lead_cnt + 4'd1;
                    txd_nxt  = (lead_cnt + 4'd1 == LEAD_CNT) ? SFD_BYTE : PRE_BYTE;
                    en_nxt   = 1'b1;
                end else begin
                    // Lead slots exhausted with no data: zero-length frame.
                    fault = 1'b1;
                end
            end

            DATA: begin
                if (!strobe_l) begin
                    fault = 1'b1;
                end else if (strobe_s) begin
                    txd_nxt = mac_data;
                    en_nxt  = 1'b1;
                    crc_nxt = crc_step(crc, mac_data);
                end else begin
                    state_nxt = FCS;
                    trl_nxt   = 3'd1;
                    txd_nxt   = ~crc[7:0];
                    en_nxt    = 1'b1;
                end
            end

            FCS: begin
                if (trl_cnt < 3'd4) begin
                    if (strobe_l && !strobe_s) begin
                        trl_nxt = trl_cnt + 3'd1;
                        txd_nxt = ~fcs_word[7:0];
                        en_nxt  = 1'b1;
                    end else begin
                        fault = 1'b1;
                    end
                end else if (!strobe_l && !strobe_s) begin
                    state_nxt = IDLE;
                    crc_nxt   = CRC_INIT;
                    lead_nxt  = 4'd0;
                    trl_nxt   = 3'd0;
                end else begin
                    fault = 1'b1;
                end
            end

            ABORT: begin
                if (!strobe_l && !strobe_s) begin
                    state_nxt = IDLE;
                    crc_nxt   = CRC_INIT;
                end
            end

            default: begin
                state_nxt = IDLE;
                crc_nxt   = CRC_INIT;
            end
        endcase

        // A mid-frame violation is marked on the wire with a single tx_er cycle.
        if (fault) begin
            state_nxt = ABORT;
            lead_nxt  = 4'd0;
            trl_nxt   = 3'd0;
            crc_nxt   = CRC_INIT;
            txd_nxt   = 8'h00;
            en_nxt    = 1'b1;
            er_nxt    = 1'b1;
        end
    end

    always_ff @(posedge tx_clk) begin
        if (rst) begin
            state      <= IDLE;
            lead_cnt   <= 4'd0;
            trl_cnt    <= 3'd0;
            crc        <= CRC_INIT;
            gmii_txd   <= 8'h00;
            gmii_tx_en <= 1'b0;
            gmii_tx_er <= 1'b0;
        end else begin
            state      <= state_nxt;
            lead_cnt   <= lead_nxt;
            trl_cnt    <= trl_nxt;
            crc        <= crc_nxt;
            gmii_txd   <= txd_nxt;
            gmii_tx_en <= en_nxt;
            gmii_tx_er <= er_nxt;
        end
    end

    assign busy = (state != IDLE);

`ifdef GMII_TX_STATS_EN
    logic [15:0] frame_cnt_q;
    logic [15:0] err_cnt_q;

    // Counting on state transitions covers both IDLE-entry and mid-frame errors uniformly.
    always_ff @(posedge tx_clk) begin
        if (rst) begin
            frame_cnt_q <= 16'd0;
            err_cnt_q   <= 16'd0;
        end else begin
            if (state == FCS && state_nxt == IDLE) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (state != ABORT && state_nxt == ABORT) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign frame_count = frame_cnt_q;
    assign err_count   = err_cnt_q;
`else
    assign frame_count = 16'd0;
    assign err_count   = 16'd0;
`endif

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Self-checking bench for gmii_tx_framer: frame-level expectation queue plus literal checks of known CRCs.
module tb_gmii_tx_framer;

    localparam int LEAD = 4;
`ifdef GMII_TX_STATS_EN
    localparam logic [15:0] STAT_MASK = 16'hFFFF;
`else
    localparam logic [15:0] STAT_MASK = 16'h0000;
`endif

    logic        tx_clk = 1'b0;
    logic        rst = 1'b1;
    logic        strobe_s = 1'b0;
    logic        strobe_l = 1'b0;
    logic [7:0]  mac_data = 8'h00;
    logic [7:0]  gmii_txd;
    logic        gmii_tx_en;
    logic        gmii_tx_er;
    logic        busy;
    logic [15:0] frame_count;
    logic [15:0] err_count;

    gmii_tx_framer #(.LEAD(LEAD)) dut (
        .tx_clk     (tx_clk),
        .rst        (rst),
        .strobe_s   (strobe_s),
        .strobe_l   (strobe_l),
        .mac_data   (mac_data),
        .gmii_txd   (gmii_txd),
        .gmii_tx_en (gmii_tx_en),
        .gmii_tx_er (gmii_tx_er),
        .busy       (busy),
        .frame_count(frame_count),
        .err_count  (err_count)
    );

    always #5 tx_clk = ~tx_clk;

    typedef struct packed {
        logic [7:0]  txd;
        logic        en;
        logic        er;
        logic        bsy;
        logic [15:0] fc;
        logic [15:0] ec;
    } out_t;

    out_t        exp_q[$];
    logic [7:0]  cap[$];
    logic [7:0]  payload[$];
    int          compared = 0;
    int          mismatched = 0;
    int          exp_frames = 0;
    int          exp_errs = 0;
    logic [31:0] model_crc;
    logic [31:0] crc_tab [256];

    logic [7:0] want1 [17] = '{8'h55, 8'h55, 8'h55, 8'hD5, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                               8'h36, 8'h37, 8'h38, 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};
    logic [7:0] want2 [9]  = '{8'h55, 8'h55, 8'h55, 8'hD5, 8'h00, 8'h8D, 8'hEF, 8'h02, 8'hD2};

    function automatic logic [15:0] stat(input int v);
        return 16'(v) & STAT_MASK;
    endfunction

    function automatic logic [7:0] rnd();
        return 8'($urandom);
    endfunction

    function automatic logic [31:0] crcByte(input logic [31:0] c, input logic [7:0] b);
        return crc_tab[c[7:0] ^ b] ^ (c >> 8);
    endfunction

    // Every cycle whose expectation was queued is compared one clock later.
    always @(posedge tx_clk) begin
        out_t e;
        out_t a;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{txd: gmii_txd, en: gmii_tx_en, er: gmii_tx_er, bsy: busy,
                  fc: frame_count, ec: err_count};
            compared++;
            if (a !== e) begin
                mismatched++;
                $display("[TB] FAIL cycle_out @%0t: got txd=%02h en=%b er=%b busy=%b fc=%0d ec=%0d, expected txd=%02h en=%b er=%b busy=%b fc=%0d ec=%0d",
                         $time, a.txd, a.en, a.er, a.bsy, a.fc, a.ec,
                         e.txd, e.en, e.er, e.bsy, e.fc, e.ec);
            end
        end
        if (gmii_tx_en && !gmii_tx_er) cap.push_back(gmii_txd);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        compared++;
        if (act !== want) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic l, input logic s, input logic [7:0] d,
                                 input logic [7:0] et, input logic ee, input logic eer, input logic eb);
        out_t e;
        @(negedge tx_clk);
        rst      = r;
        strobe_l = l;
        strobe_s = s;
        mac_data = d;
        e = '{txd: et, en: ee, er: eer, bsy: eb, fc: stat(exp_frames), ec: stat(exp_errs)};
        exp_q.push_back(e);
    endtask

    task automatic resetCycle();
        exp_frames = 0;
        exp_errs   = 0;
        applyStimulus(1'b1, 1'($urandom), 1'($urandom), rnd(), 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic leadCycles(input int k);
        for (int i = 1; i <= k; i++)
            applyStimulus(1'b0, 1'b1, 1'b0, rnd(), (i == LEAD) ? 8'hD5 : 8'h55, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic dataCycles(input int k);
        model_crc = 32'hFFFF_FFFF;
        for (int i = 0; i < k; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, payload[i], payload[i], 1'b1, 1'b0, 1'b1);
            model_crc = crcByte(model_crc, payload[i]);
        end
    endtask

    task automatic trailerCycles(input int k);
        logic [31:0] fcs;
        fcs = ~model_crc;
        for (int i = 0; i < k; i++)
            applyStimulus(1'b0, 1'b1, 1'b0, rnd(), fcs[8*i +: 8], 1'b1, 1'b0, 1'b1);
    endtask

    task automatic errorCycle(input logic l, input logic s);
        exp_errs++;
        applyStimulus(1'b0, l, s, rnd(), 8'h00, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic idleError(input logic l);
        exp_errs++;
        applyStimulus(1'b0, l, 1'b1, rnd(), 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic abortCycles(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 1'b1, 1'($urandom), rnd(), 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic gapCycles(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, rnd(), 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic makePayload(input int n);
        payload.delete();
        for (int i = 0; i < n; i++) payload.push_back(rnd());
    endtask

    task automatic sendGood(input int gap);
        leadCycles(LEAD);
        dataCycles(payload.size());
        trailerCycles(4);
        exp_frames++;
        gapCycles(gap);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge tx_clk);
            #2;
            guard++;
        end
        if (exp_q.size() > 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int sc;
        int k;
        int t;
        int n;
        logic [1:0] pick;

        for (int i = 0; i < 256; i++) begin
            logic [31:0] c;
            c = 32'(i);
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tab[i] = c;
        end

        resetCycle();
        resetCycle();
        drain();
        checkOutput("reset_en", {31'd0, gmii_tx_en}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);

        // "123456789" frame with known FCS
        cap.delete();
        payload.delete();
        for (int i = 0; i < 9; i++) payload.push_back(8'h31 + 8'(i));
        sendGood(2);
        drain();
        checkOutput("t1_len", cap.size(), 17);
        for (int i = 0; i < 17 && i < cap.size(); i++) checkOutput("t1_byte", cap[i], want1[i]);
        checkOutput("t1_frames", frame_count, stat(1));

        // Two single-zero-byte frames back to back
        resetCycle();
        drain();
        cap.delete();
        payload.delete();
        payload.push_back(8'h00);
        sendGood(1);
        sendGood(1);
        drain();
        checkOutput("t2_len", cap.size(), 18);
        for (int i = 0; i < 18 && i < cap.size(); i++) checkOutput("t2_byte", cap[i], want2[i % 9]);
        checkOutput("t2_frames", frame_count, stat(2));
        checkOutput("t2_errs", err_count, stat(0));

        // strobe_s on lead cycle 3, then a good frame
        resetCycle();
        leadCycles(2);
        errorCycle(1'b1, 1'b1);
        abortCycles(3);
        gapCycles(2);
        drain();
        checkOutput("t3_errs", err_count, stat(1));
        checkOutput("t3_busy", {31'd0, busy}, 32'd0);
        cap.delete();
        makePayload(6);
        sendGood(2);
        drain();
        checkOutput("t3_follow_len", cap.size(), 14);

        // Both strobes drop after 5 data bytes
        makePayload(8);
        leadCycles(LEAD);
        dataCycles(5);
        errorCycle(1'b0, 1'b0);
        gapCycles(2);

        // strobe_l held one cycle past the trailer
        makePayload(3);
        leadCycles(LEAD);
        dataCycles(3);
        trailerCycles(4);
        errorCycle(1'b1, 1'b0);
        abortCycles(1);
        gapCycles(2);

        // Reset during data byte 3
        makePayload(10);
        leadCycles(LEAD);
        dataCycles(2);
        resetCycle();
        drain();
        checkOutput("t6_en", {31'd0, gmii_tx_en}, 32'd0);
        checkOutput("t6_frames", frame_count, 32'd0);
        checkOutput("t6_errs", err_count, 32'd0);
        gapCycles(1);
        makePayload(4);
        sendGood(2);

        for (int it = 0; it < 200; it++) begin
            sc = $urandom_range(0, 8);
            case (sc)
                0, 1, 2: begin
                    makePayload($urandom_range(1, 16));
                    sendGood($urandom_range(1, 3));
                end
                3: begin
                    k = $urandom_range(1, LEAD);
                    if (k == 1) idleError(1'($urandom));
                    else begin
                        leadCycles(k - 1);
                        errorCycle(1'b1, 1'b1);
                    end
                    abortCycles($urandom_range(0, 3));
                    gapCycles($urandom_range(1, 3));
                end
                4: begin
                    leadCycles(LEAD);
                    errorCycle(1'b1, 1'b0);
                    abortCycles($urandom_range(0, 2));
                    gapCycles($urandom_range(1, 3));
                end
                5: begin
                    leadCycles($urandom_range(1, LEAD));
                    errorCycle(1'b0, 1'($urandom));
                    gapCycles($urandom_range(1, 3));
                end
                6: begin
                    n = $urandom_range(2, 10);
                    makePayload(n);
                    leadCycles(LEAD);
                    dataCycles($urandom_range(1, n));
                    errorCycle(1'b0, 1'($urandom));
                    gapCycles($urandom_range(1, 3));
                end
                7: begin
                    makePayload($urandom_range(1, 8));
                    leadCycles(LEAD);
                    dataCycles(payload.size());
                    t = $urandom_range(1, 4);
                    trailerCycles(t);
                    pick = 2'($urandom_range(0, 2));
                    if (t < 4) begin
                        if (pick == 2'd0) errorCycle(1'b0, 1'b0);
                        else if (pick == 2'd1) errorCycle(1'b0, 1'b1);
                        else errorCycle(1'b1, 1'b1);
                    end else begin
                        if (pick == 2'd0) errorCycle(1'b1, 1'b0);
                        else if (pick == 2'd1) errorCycle(1'b0, 1'b1);
                        else errorCycle(1'b1, 1'b1);
                    end
                    abortCycles($urandom_range(0, 2));
                    gapCycles($urandom_range(1, 3));
                end
                default: begin
                    idleError(1'b1);
                    abortCycles($urandom_range(2, 6));
                    gapCycles(1);
                    makePayload($urandom_range(1, 5));
                    sendGood(1);
                end
            endcase
        end

        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/gmii_tx_framer.md
Name: gmii_tx_framer

Overview:
Downstream neighbour of the MAC transmit subset, placed after the output multiplexer. Consumes the byte stream `mac_data` and its two strobes: `strobe_s` marks data bytes only; `strobe_l` also covers the lead and trailer slots. Fills the lead slots with preamble/SFD, passes data through while computing Ethernet CRC-32, and fills the trailer slots with the FCS. Drives GMII transmit pins and flags protocol violations.

Parameters:
LEAD, 4, number of `strobe_l` cycles before the first `strobe_s` cycle; range 1..8; must match upstream stretch.

Ports:
tx_clk  input  1  transmit clock; all logic on its rising edge
rst  input  1  synchronous, active-high reset
strobe_s  input  1  data-byte valid
strobe_l  input  1  frame envelope: LEAD lead + data + 4 trailer cycles
mac_data  input  8  payload byte, valid when strobe_s=1
gmii_txd  output  8  GMII transmit data
gmii_tx_en  output  1  GMII transmit enable
gmii_tx_er  output  1  GMII transmit error (one-cycle abort marker)
busy  output  1  high when state is not IDLE
frame_count  output  16  good frames sent (TX_STATS_EN only)
err_count  output  16  protocol violations (TX_STATS_EN only)

Behaviour:
- Clock and reset: one clock, `tx_clk`; reset `rst` is synchronous, active-high.
- On reset:
  - state IDLE; all outputs 0.
  - CRC register = 0xFFFFFFFF.
  - Lead/trailer counters 0; stats counters 0.
- Latency: all outputs registered, exactly 1 cycle after the corresponding input cycle.
- States: IDLE, PRE, DATA, FCS, ABORT.
- IDLE:
  - `strobe_l`=1, `strobe_s`=0 -> PRE; lead count = 1; output byte 0x55 (0xD5 if LEAD=1); `tx_en`=1.
  - `strobe_s`=1 (with or without `strobe_l`) -> ABORT; error counted; `tx_en`/`tx_er` stay 0.
- PRE, `strobe_l`=1, `strobe_s`=0, lead count < LEAD: output 0x55, or 0xD5 when this is lead cycle LEAD; count++.
- PRE -> DATA: first `strobe_s`=1 cycle with count == LEAD. Output `mac_data`.
- PRE errors (each -> error):
  - `strobe_s` before count reaches LEAD;
  - `strobe_s`=0 after count == LEAD;
  - `strobe_l`=0.
- DATA, `strobe_s`=1 (`strobe_l` must also be 1):
  - `gmii_txd` = `mac_data`.
  - CRC updated: reflected polynomial 0xEDB88320, LSB-first, one byte per cycle.
- DATA -> FCS: `strobe_s`=0, `strobe_l`=1.
  - Output FCS byte 0 = ~crc[7:0]; trailer count = 1.
  - FCS byte k = ~crc[8k+7:8k].
- DATA errors: `strobe_l`=0, or `strobe_s`=1 with `strobe_l`=0 -> error.
- FCS:
  - While trailer count < 4, requires `strobe_l`=1, `strobe_s`=0; emits the next FCS byte.
  - After 4 bytes, requires `strobe_l`=0 -> IDLE; `tx_en`=0; CRC reinitialised; `frame_count`++.
  - Errors: `strobe_l` still 1, early `strobe_l` drop, or `strobe_s`=1.
- Error (from PRE/DATA/FCS):
  - That output cycle: `tx_en`=1, `tx_er`=1, `txd`=0x00.
  - Then ABORT; `err_count`++.
- ABORT:
  - `tx_en`=0, `tx_er`=0, `txd`=0.
  - Stays until a cycle with `strobe_l`=0 and `strobe_s`=0, then IDLE with CRC reinitialised.
  - A fresh `strobe_l` rise is not accepted until that idle cycle is seen.
- Back-to-back frames: the FCS->IDLE cycle (`strobe_l`=0) counts as the required gap. A new `strobe_l` may start on the very next cycle.
- Zero-length frame (no `strobe_s`) is an error at lead cycle LEAD+1.
- Counters: 16-bit, wrap 0xFFFF->0.
- Reset mid-frame: outputs 0 on the cycle after `rst`; no FCS emitted.

Optional Feature:
- Macro: `GMII_TX_STATS_EN`.
- Defined: `frame_count` and `err_count` are live as described.
- Undefined: both ports are driven constant 0 and the counter registers are not instantiated. The rest of the behaviour is unchanged, including `tx_er`.

Test Plan:
1. LEAD=4; ASCII "123456789" (0x31..0x39).
   - Stimulus: `strobe_l` 17 cycles, `strobe_s` on cycles 5-13.
   - Required: `txd` = 55 55 55 D5 31..39 26 39 F4 CB; `tx_en` high exactly 17 cycles, one cycle delayed; `frame_count`=1.
2. Single byte 0x00, then a second identical frame after a 1-cycle gap.
   - Required: both emit FCS 8D EF 02 D2 (CRC reinitialised); `frame_count`=2; `err_count`=0.
3. `strobe_s` rises on lead cycle 3.
   - Required: output on that cycle `tx_en`=1, `tx_er`=1, `txd`=00; then `tx_en`=0 until `strobe_l` falls; `err_count`=1.
   - Follow-up: a subsequent nominal frame is framed correctly.
4. `strobe_l` and `strobe_s` drop together mid-data after 5 bytes.
   - Required: `tx_er` pulse; no FCS bytes; `busy` returns to 0 once the idle cycle is seen; `frame_count` unchanged.
5. `strobe_l` held 1 cycle past the 4 trailer cycles.
   - Required: FCS bytes correct, then a `tx_er` pulse on the 5th trailer slot; `err_count`++.
6. `rst` asserted during data byte 3.
   - Required: next cycle all outputs 0 and counters 0; next nominal frame correct.
